osc_bank: RTL and testbench
===========================

# osc_bank

Multi-channel, synthesizable programmable clock/strobe generator for the verify platform. Each of `CHANNELS` channels produces a divided clock with a programmable period and phase offset, derived from the single system clock. Configuration changes take effect glitch-free at period boundaries. An all-channel `sync_start` phase-aligns the bank. The block drives stimulus clocks and tick strobes for the controller and DUT harness.

## Interface
- `CHANNELS`, 4, number of independent output channels (1..16).
- `CNT_W`, 16, width of the period and phase fields, in clk cycles.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  CHANNELS  per-channel run enable, level-sensitive.
- `sync_start`  in  1  single-cycle pulse that restarts all enabled channels together.
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_ch`  in  4  channel index for the write; an index ≥ CHANNELS makes the write a no-op.
- `cfg_period`  in  CNT_W  full output period P, in clk cycles.
- `cfg_phase`  in  CNT_W  start delay D, in clk cycles.
- `clk_out`  out  CHANNELS  generated clocks, registered.
- `tick`  out  CHANNELS  one-cycle pulse in the first cycle that `clk_out` is high.
- `busy`  out  CHANNELS  channel state is not OFF.

## Operation
- Each channel has two register sets: a shadow set {P, D} and an active set.
  - `cfg_wr` writes the shadow set on the clock edge.
  - P < 2 is stored as 2.
- Derived active times:
  - H = P>>1 (high time).
  - L = P − H (low time). An odd P gives the extra cycle to the low phase.
- Per-channel FSM with states OFF, PHASE, LOW, HIGH. A down-counter is loaded on each state entry.
  - **OFF:** the shadow set is copied to the active set continuously. On `enable` = 1, go to PHASE (count D), or to LOW if D = 0.
  - **PHASE:** after D cycles, go to LOW (count L).
  - **LOW:** after L cycles, go to HIGH (count H).
  - **HIGH:** after H cycles, copy shadow to active, then go to LOW (count the new L). This is the only point where a running channel picks up a new configuration.
- Outputs: `clk_out` = (state == HIGH); `tick` = first cycle of HIGH; `busy` = (state ≠ OFF).
- Disable, i.e. `enable` falls:
  - From PHASE or LOW: go to OFF on the next edge.
  - From HIGH: finish the remaining high time, then go to OFF. No runt high pulses are produced.
- Re-enable during the finishing HIGH phase: the channel continues normally to LOW.
- `sync_start`: every channel with `enable` = 1 copies shadow to active and enters PHASE (or LOW if D = 0) on that edge, regardless of its current state.
  - This may truncate a high pulse; that is intentional.
  - Channels with `enable` = 0 ignore it.
- `cfg_wr` and `sync_start` on the same edge: the restart uses the pre-write shadow set; the written value applies at the next period boundary.
- `enable` rise and `sync_start` on the same edge: identical result (enter PHASE).
- Counters never wrap: the maximum P is 2^CNT_W − 1, with no truncation.

## Timing
- Reset values: every `clk_out` = 0, `tick` = 0, `busy` = 0; all FSMs in OFF; shadow and active sets = {P = 2, D = 0}.
- Reference edge: `enable` is sampled high at edge k.
  - First rising edge of `clk_out` occurs after edge k + D + L.
  - Steady state: period P, high for H cycles.
- `busy` rises after edge k, with 1-cycle latency from `enable`.
- A configuration write takes effect after the HIGH→LOW transition that follows the write; the latency is at most one full old period.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset mid-run:** ch0 P = 4, D = 0, enable; assert `rst` at an arbitrary cycle. Expect `clk_out`/`tick`/`busy` = 0 asynchronously, and the default P = 2 square wave after re-enable.
- **Odd period and phase:** ch1 P = 5, D = 3, enable at edge 10. Expect the first rise after edge 16, high 2 cycles / low 3 cycles, and `tick` once per period.
- **Glitch-free reconfiguration:** ch2 running at P = 8; write P = 4 mid-HIGH. Expect the current 4-cycle high to complete, then 2/2 cycles thereafter. There must be no pulse shorter than min(old, new) H.
- **Graceful disable:** ch3 P = 10; drop `enable` in the 2nd high cycle. Expect high to last the full 5 cycles, then `busy` = 0. Dropping `enable` in LOW gives OFF on the next edge.
- **Sync alignment:**
  - Stimulus: ch0 D = 0, ch1 D = 2, both P = 6 and free-running; pulse `sync_start`.
  - Expect both restarted, with ch1's rise 2 cycles after ch0's.
  - Simultaneous `cfg_wr` to ch0 with P = 12: the restart uses P = 6, and P = 12 applies after the first HIGH.
- **Edge cases:** P = 0 and P = 1 give P = 2 behaviour; `cfg_ch` = CHANNELS gives no state change; P = 0xFFFF gives H = 32767, L = 32768.

Source files
------------

// File: rtl/osc_bank.sv
`default_nettype none
// ============================================================================
// osc_bank : multi-channel programmable clock/strobe generator
// Rev 1.0
// ============================================================================
module osc_bank #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] enable,
   input  logic                sync_start,
   input  logic                cfg_wr,
   input  logic [3:0]          cfg_ch,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [CNT_W-1:0]    cfg_phase,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] busy
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_PHASE = 2'd1,
      ST_LOW   = 2'd2,
      ST_HIGH  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_min_period = CNT_W'(2);
   localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_zero       = '0;

   logic [CNT_W-1:0] w_wr_period;
   assign w_wr_period = (cfg_period < c_min_period) ? c_min_period : cfg_period;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] sh_p_q, sh_p_d;
      logic [CNT_W-1:0] sh_d_q, sh_d_d;
      logic [CNT_W-1:0] act_p_q, act_p_d;
      logic [CNT_W-1:0] w_sh_h, w_sh_l, w_act_h, w_act_l;
      logic             w_wr_sel, w_restart;
      logic             clk_out_q, tick_q, busy_q;

      assign w_wr_sel = cfg_wr && (cfg_ch == 4'(g));
      assign w_sh_h   = sh_p_q >> 1;
      assign w_sh_l   = sh_p_q - w_sh_h;
      assign w_act_h  = act_p_q >> 1;
      assign w_act_l  = act_p_q - w_act_h;

      // The active phase is only consumed at (re)start, and every start reads
      // it straight from the shadow set, so only the active period is stored.
      always_comb begin
         sh_p_d    = sh_p_q;
         sh_d_d    = sh_d_q;
         state_d   = state_q;
         cnt_d     = cnt_q;
         act_p_d   = act_p_q;
         w_restart = 1'b0;

         if (w_wr_sel) begin
            sh_p_d = w_wr_period;
            sh_d_d = cfg_phase;
         end

         if (enable[g] && sync_start) begin
            w_restart = 1'b1;
         end else begin
            case (state_q)
               ST_OFF: begin
                  act_p_d = sh_p_q;
                  if (enable[g]) w_restart = 1'b1;
               end
               ST_PHASE: begin
                  if (!enable[g]) begin
                     state_d = ST_OFF;
                  end else if (cnt_q == c_zero) begin
                     state_d = ST_LOW;
                     cnt_d   = w_act_l - c_one;
                  end else begin
                     cnt_d = cnt_q - c_one;
                  end
               end
               ST_LOW: begin
                  if (!enable[g]) begin
                     state_d = ST_OFF;
                  end else if (cnt_q == c_zero) begin
                     state_d = ST_HIGH;
                     cnt_d   = w_act_h - c_one;
                  end else begin
                     cnt_d = cnt_q - c_one;
                  end
               end
               default: begin
                  // High time always completes; only its end is a boundary.
                  if (cnt_q == c_zero) begin
                     act_p_d = sh_p_q;
                     if (enable[g]) begin
                        state_d = ST_LOW;
                        cnt_d   = w_sh_l - c_one;
                     end else begin
                        state_d = ST_OFF;
                     end
                  end else begin
                     cnt_d = cnt_q - c_one;
                  end
               end
            endcase
         end

         if (w_restart) begin
            act_p_d = sh_p_q;
            if (sh_d_q == c_zero) begin
               state_d = ST_LOW;
               cnt_d   = w_sh_l - c_one;
            end else begin
               state_d = ST_PHASE;
               cnt_d   = sh_d_q - c_one;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            sh_p_q    <= c_min_period;
            sh_d_q    <= '0;
            act_p_q   <= c_min_period;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_p_q    <= sh_p_d;
            sh_d_q    <= sh_d_d;
            act_p_q   <= act_p_d;
            clk_out_q <= (state_d == ST_HIGH);
            tick_q    <= (state_d == ST_HIGH) && (state_q != ST_HIGH);
            busy_q    <= (state_d != ST_OFF);
         end
      end

      assign clk_out[g] = clk_out_q;
      assign tick[g]    = tick_q;
      assign busy[g]    = busy_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_osc_bank.sv
`default_nettype none
// ============================================================================
// tb_osc_bank : self-checking bench for osc_bank (timeline reference model)
// Rev 1.0
// ============================================================================
module tb_osc_bank;

   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] enable = '0;
   logic          sync_start = 1'b0;
   logic          cfg_wr = 1'b0;
   logic [3:0]    cfg_ch = '0;
   logic [15:0]   cfg_period = '0;
   logic [15:0]   cfg_phase = '0;
   logic [CH-1:0] clk_out, tick, busy;

   osc_bank #(.CHANNELS(CH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .sync_start(sync_start),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
      .cfg_phase(cfg_phase), .clk_out(clk_out), .tick(tick), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int nprint = 0;
   bit started = 1'b0;

   // Reference model: each running channel is a timeline anchored at t0, the
   // edge after which its current low interval begins (t0 > n while in phase).
   longint n;
   longint m_sh_p[CH], m_sh_d[CH], m_p[CH], m_t0[CH];
   bit     m_run[CH];
   longint m_rel, m_l;
   logic [CH-1:0] exp_clk, exp_tick, exp_busy;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n = 0;
         for (int c = 0; c < CH; c++) begin
            m_sh_p[c] = 2; m_sh_d[c] = 0; m_p[c] = 2; m_t0[c] = 0; m_run[c] = 0;
         end
         exp_clk = '0; exp_tick = '0; exp_busy = '0;
      end else begin
         n = n + 1;
         for (int c = 0; c < CH; c++) begin
            m_l   = m_p[c] - m_p[c] / 2;
            m_rel = n - m_t0[c];
            if (enable[c] && (sync_start || !m_run[c])) begin
               m_p[c] = m_sh_p[c]; m_t0[c] = n + m_sh_d[c]; m_run[c] = 1;
            end else if (m_run[c]) begin
               if (m_rel == m_p[c]) begin
                  if (enable[c]) begin m_t0[c] = n; m_p[c] = m_sh_p[c]; end
                  else m_run[c] = 0;
               end else if (m_rel <= m_l && !enable[c]) begin
                  m_run[c] = 0;
               end
            end
            if (cfg_wr && int'(cfg_ch) == c) begin
               m_sh_p[c] = (cfg_period < 2) ? 2 : longint'(cfg_period);
               m_sh_d[c] = longint'(cfg_phase);
            end
            m_l   = m_p[c] - m_p[c] / 2;
            m_rel = n - m_t0[c];
            exp_busy[c] = m_run[c];
            exp_clk[c]  = m_run[c] && (m_rel >= m_l);
            exp_tick[c] = m_run[c] && (m_rel == m_l);
         end
      end
   end

   always @(negedge clk) begin
      if (started && !rst) begin
         checks++;
         if ({clk_out, tick, busy} !== {exp_clk, exp_tick, exp_busy}) begin
            failures++;
            if (nprint < 20) begin
               nprint++;
               $display("FAIL model_cmp t=%0t clk_out=%b/%b tick=%b/%b busy=%b/%b (actual/required)",
                        $time, clk_out, exp_clk, tick, exp_tick, busy, exp_busy);
            end
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cfg(input int ch, input int p, input int d);
      cfg_wr = 1'b1; cfg_ch = 4'(ch); cfg_period = 16'(p); cfg_phase = 16'(d);
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic wait_tick(input int ch);
      int k = 0;
      while (!tick[ch] && k < 300) begin @(negedge clk); k++; end
      check("wait_tick", longint'(tick[ch]), 1);
   endtask

   task automatic count_level(input int ch, input logic lvl, output int len);
      len = 0;
      while (clk_out[ch] == lvl && len < 70000) begin len++; @(negedge clk); end
   endtask

   task automatic settle();
      enable = '0;
      repeat (30) @(negedge clk);
      check("settle_busy", longint'(busy), 0);
   endtask

   int len;
   logic [3:0]  pat4a, pat4b;
   logic [12:0] pat13;
   logic [13:0] pt0, pt1;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_clk_out", longint'(clk_out), 0);
      check("rst_tick", longint'(tick), 0);
      check("rst_busy", longint'(busy), 0);
      rst = 1'b0;
      started = 1'b1;

      // Reset mid-run, then default P=2 after re-enable
      cfg(0, 4, 0);
      enable[0] = 1'b1;
      repeat ($urandom_range(3, 20)) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_clk_out", longint'(clk_out), 0);
      check("async_rst_tick", longint'(tick), 0);
      check("async_rst_busy", longint'(busy), 0);
      enable = '0;
      @(negedge clk);
      rst = 1'b0;
      enable[0] = 1'b1;
      for (int j = 0; j < 4; j++) begin @(negedge clk); pat4a[j] = clk_out[0]; end
      check("default_p2_pattern", longint'(pat4a), 4'b1010);

      // Odd period P=5 with phase D=3 on ch1
      repeat (3) @(negedge clk);
      cfg(1, 5, 3);
      enable[1] = 1'b1;
      for (int j = 0; j < 13; j++) begin @(negedge clk); pat13[j] = clk_out[1]; end
      check("p5_d3_pattern", longint'(pat13), 13'b1100011000000);

      // Glitch-free reconfiguration on ch2: 8 -> 4 written mid-HIGH
      cfg(2, 8, 0);
      enable[2] = 1'b1;
      wait_tick(2);
      cfg(2, 4, 0);
      count_level(2, 1'b1, len);
      check("reconf_old_high_rest", len, 3);
      count_level(2, 1'b0, len);
      check("reconf_new_low", len, 2);
      count_level(2, 1'b1, len);
      check("reconf_new_high", len, 2);

      // Graceful disable on ch3, P=10
      cfg(3, 10, 0);
      enable[3] = 1'b1;
      wait_tick(3);
      @(negedge clk);
      enable[3] = 1'b0;
      count_level(3, 1'b1, len);
      check("disable_high_rest", len, 4);
      check("disable_busy_after_high", longint'(busy[3]), 0);
      enable[3] = 1'b1;
      repeat (2) @(negedge clk);
      check("low_busy", longint'(busy[3]), 1);
      enable[3] = 1'b0;
      @(negedge clk);
      check("disable_in_low", longint'(busy[3]), 0);

      // Sync alignment with simultaneous write to ch0
      cfg(0, 6, 0);
      cfg(1, 6, 2);
      enable[0] = 1'b1; enable[1] = 1'b1;
      repeat (20) @(negedge clk);
      sync_start = 1'b1; cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_period = 16'd12; cfg_phase = 16'd0;
      @(negedge clk);
      sync_start = 1'b0; cfg_wr = 1'b0;
      pt0[0] = tick[0]; pt1[0] = tick[1];
      for (int j = 1; j < 14; j++) begin @(negedge clk); pt0[j] = tick[0]; pt1[j] = tick[1]; end
      check("sync_ch0_ticks", longint'(pt0), 14'b01000000001000);
      check("sync_ch1_ticks", longint'(pt1), 14'b00100000100000);

      // P=0 and P=1 behave as P=2; out-of-range channel write is ignored
      settle();
      cfg(1, 0, 0);
      cfg(2, 1, 0);
      cfg(CH, 9, 3);
      enable[1] = 1'b1; enable[2] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); pat4a[j] = clk_out[1]; pat4b[j] = clk_out[2];
      end
      check("p0_pattern", longint'(pat4a), 4'b1010);
      check("p1_pattern", longint'(pat4b), 4'b1010);

      // Maximum period
      settle();
      cfg(0, 16'hFFFF, 0);
      enable[0] = 1'b1;
      @(negedge clk);
      count_level(0, 1'b0, len);
      check("pmax_low", len, 32768);
      enable[0] = 1'b0;
      count_level(0, 1'b1, len);
      check("pmax_high", len, 32767);
      check("pmax_busy_off", longint'(busy[0]), 0);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 39) == 0) enable[c] = ~enable[c];
         cfg_wr     = ($urandom_range(0, 5) == 0);
         cfg_ch     = 4'($urandom_range(0, 5));
         cfg_period = 16'($urandom_range(0, 14));
         cfg_phase  = 16'($urandom_range(0, 6));
         sync_start = ($urandom_range(0, 49) == 0);
         @(negedge clk);
      end
      cfg_wr = 1'b0; sync_start = 1'b0;
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
